// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states and the
// byte-address to memory-address mapping.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SzByte = 2'b00,
      SzHalf = 2'b01,
      SzWord = 2'b10,
      SzRsvd = 2'b11
   } size_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRmw  = 1'b1
   } state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] addr, input bit word_index);
      return word_index ? {2'b00, addr[31:2]} : {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and sub-word requests: load extract/extend,
// store lane merge and alignment-fault detection.
module mem_lane_align
   import mem_access_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  size_e       size_i,
   input  logic        signed_i,
   input  logic [1:0]  offs_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o,
   output logic        misalign_o
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [4:0]  shamt;
   logic [31:0] mask;
   logic [15:0] lane_bits;

   always_comb begin
      byte_lane   = BIG_ENDIAN ? (2'd3 - offs_i) : offs_i;
      half_lane   = BIG_ENDIAN ? ~offs_i[1] : offs_i[1];
      shamt       = 5'd0;
      mask        = 32'hFFFF_FFFF;
      misalign_o  = 1'b0;
      unique case (size_i)
         SzByte: begin
            shamt = {byte_lane, 3'b000};
            mask  = 32'h0000_00FF;
         end
         SzHalf: begin
            shamt      = {half_lane, 4'b0000};
            mask       = 32'h0000_FFFF;
            misalign_o = offs_i[0];
         end
         SzWord: misalign_o = |offs_i;
         SzRsvd: misalign_o = 1'b1;
      endcase

      lane_bits = 16'(rdata_i >> shamt);
      unique case (size_i)
         SzByte:  load_data_o = {{24{signed_i & lane_bits[7]}}, lane_bits[7:0]};
         SzHalf:  load_data_o = {{16{signed_i & lane_bits[15]}}, lane_bits};
         default: load_data_o = rdata_i;
      endcase

      // Upper bits of the store data are dropped by the mask before shifting into the lane.
      merged_o = (rdata_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: single-cycle loads and word stores, two-cycle
// read-modify-write for byte/half stores, registered responses.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter bit WORD_INDEX = 1'b0,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_misalign_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_write_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   state_e      state_q, state_d;
   logic [31:0] merged_q, merged_d;
   logic [31:0] addr_q, addr_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_mis_q, rsp_mis_d;

   size_e       req_size;
   logic        accept;
   logic        sub_store;
   logic [31:0] req_mem_addr;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic        misalign;

   assign req_size     = size_e'(req_size_i);
   assign req_mem_addr = word_addr(req_addr_i, WORD_INDEX);

   mem_lane_align #(
      .BIG_ENDIAN(BIG_ENDIAN)
   ) u_lane_align (
      .size_i     (req_size),
      .signed_i   (req_signed_i),
      .offs_i     (req_addr_i[1:0]),
      .wdata_i    (req_wdata_i),
      .rdata_i    (mem_rdata_i),
      .load_data_o(load_data),
      .merged_o   (merged),
      .misalign_o (misalign)
   );

   always_comb begin
      req_ready_o = (state_q == StIdle) && !rst_i;
      accept      = req_valid_i && req_ready_o;
      sub_store   = req_we_i && ((req_size == SzByte) || (req_size == SzHalf));

      state_d     = StIdle;
      merged_d    = merged_q;
      addr_d      = addr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'd0;
      rsp_mis_d   = 1'b0;

      if (state_q == StRmw) begin
         rsp_valid_d = 1'b1;
      end else if (accept) begin
         if (misalign) begin
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
         end else if (sub_store) begin
            state_d  = StRmw;
            merged_d = merged;
            addr_d   = req_mem_addr;
         end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we_i ? 32'd0 : load_data;
         end
      end

      // In RMW the write depends only on state, so req_valid cannot reach mem_write.
      mem_addr_o  = (state_q == StRmw) ? addr_q : req_mem_addr;
      mem_wdata_o = (state_q == StRmw) ? merged_q : req_wdata_i;
      mem_write_o = !rst_i && ((state_q == StRmw) ||
                               (accept && req_we_i && (req_size == SzWord) && !misalign));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         merged_q    <= 32'd0;
         addr_q      <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_mis_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         merged_q    <= merged_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_mis_q   <= rsp_mis_d;
      end
   end

   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign rsp_misalign_o = rsp_mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard queue and an independent response monitor.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_misalign;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write;

   logic [31:0] mem [16];
   logic        bd_we;
   logic [3:0]  bd_idx;
   logic [31:0] bd_data;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .WORD_INDEX(1'b0),
      .BIG_ENDIAN(1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_we_i      (req_we),
      .req_size_i    (req_size),
      .req_signed_i  (req_signed),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_misalign_o(rsp_misalign),
      .mem_addr_o    (mem_addr),
      .mem_write_o   (mem_write),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata)
   );

   // Data memory model: combinational read, posedge write, plus a backdoor write port.
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && rsp_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
         end else begin
            e = sb_q.pop_front();
            check32("rsp_rdata", rsp_rdata, e.rdata);
            check32("rsp_misalign", {31'd0, rsp_misalign}, {31'd0, e.mis});
         end
      end
   end

   task automatic bd_write(input logic [3:0] idx, input logic [31:0] data);
      bd_we   = 1'b1;
      bd_idx  = idx;
      bd_data = data;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // Presents a request, waits (bounded) for acceptance, checks mem_write in the accept cycle.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_wr,
                        input logic want_rsp, output int waits);
      exp_t e;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      waits      = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) break;
         waits++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
      end else begin
         check32("accept_mem_write", {31'd0, mem_write}, {31'd0, exp_wr});
         if (want_rsp) begin
            e.rdata = exp_rd;
            e.mis   = exp_mis;
            sb_q.push_back(e);
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   initial begin : stim
      int w;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'h0010_0000;
      req_wdata  = 32'd0;
      bd_we      = 1'b0;
      bd_idx     = 4'd0;
      bd_data    = 32'd0;
      @(posedge clk);
      #1;
      bd_write(4'd0, 32'h1122_3344);
      bd_write(4'd1, 32'h8000_0000);
      bd_write(4'd2, 32'h0000_0000);
      bd_write(4'd3, 32'h0000_0000);

      @(negedge clk);
      check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check32("reset_rsp_rdata", rsp_rdata, 32'd0);
      check32("reset_rsp_misalign", {31'd0, rsp_misalign}, 32'd0);
      check32("reset_mem_write", {31'd0, mem_write}, 32'd0);
      check32("reset_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("post_reset_ready", {31'd0, req_ready}, 32'd1);
      check32("idle_mem_write", {31'd0, mem_write}, 32'd0);
      @(posedge clk);
      #1;

      // Loads with lane extraction and sign/zero extension
      issue(1'b0, 2'b00, 1'b1, 32'h0010_0001, 32'd0, 32'h0000_0022, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b00, 1'b0, 32'h0010_0004, 32'd0, 32'h0000_0080, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b00, 1'b1, 32'h0010_0004, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b01, 1'b1, 32'h0010_0004, 32'd0, 32'hFFFF_8000, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b01, 1'b0, 32'h0010_0004, 32'd0, 32'h0000_8000, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'd0, 32'h1122_3344, 1'b0, 1'b0, 1'b1, w);

      // SB: write only in the RMW cycle, with upper store bits ignored
      issue(1'b1, 2'b00, 1'b0, 32'h0010_0002, 32'hFFFF_FFAB, 32'd0, 1'b0, 1'b0, 1'b1, w);
      @(negedge clk);
      check32("rmw_req_ready", {31'd0, req_ready}, 32'd0);
      check32("rmw_mem_write", {31'd0, mem_write}, 32'd1);
      check32("rmw_mem_wdata", mem_wdata, 32'h1122_AB44);
      check32("rmw_mem_addr", mem_addr, 32'h0010_0000);
      @(posedge clk);
      #1;

      // Alignment faults: no write, misalign response with zero data
      issue(1'b0, 2'b01, 1'b1, 32'h0010_0001, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, w);
      issue(1'b0, 2'b11, 1'b0, 32'h0010_0000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, w);
      issue(1'b1, 2'b10, 1'b0, 32'h0010_0002, 32'h5555_5555, 32'd0, 1'b1, 1'b0, 1'b1, w);
      issue(1'b1, 2'b01, 1'b0, 32'h0010_0003, 32'h0000_7777, 32'd0, 1'b1, 1'b0, 1'b1, w);
      @(negedge clk);
      check32("mem_after_sb_faults", mem[0], 32'h1122_AB44);
      @(posedge clk);
      #1;

      // SH then LW immediately: LW held off one cycle, sees merged word
      bd_write(4'd0, 32'h1122_3344);
      issue(1'b1, 2'b01, 1'b0, 32'h0010_0000, 32'h1234_CAFE, 32'd0, 1'b0, 1'b0, 1'b1, w);
      issue(1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'd0, 32'hCAFE_3344, 1'b0, 1'b0, 1'b1, w);
      check32("lw_after_sh_waits", w, 32'd1);

      // SW then LW back-to-back
      issue(1'b1, 2'b10, 1'b0, 32'h0010_0008, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b1, w);
      check32("sw_waits", w, 32'd0);
      issue(1'b0, 2'b10, 1'b0, 32'h0010_0008, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, w);
      check32("lw_after_sw_waits", w, 32'd0);

      // Reset during the RMW cycle aborts the write and the response
      bd_write(4'd0, 32'h1122_3344);
      issue(1'b1, 2'b00, 1'b0, 32'h0010_0000, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 1'b0, w);
      rst = 1'b1;
      @(negedge clk);
      check32("rst_rmw_mem_write", {31'd0, mem_write}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
      check32("rst_rmw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check32("rst_rmw_mem", mem[0], 32'h1122_3344);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      check32("scoreboard_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
